mc_alu: RTL and testbench

MC_ALU -- requirements
Module: mc_alu

---
 rtl/mc_alu.sv | 176 +++++++++++++++++
 tb/tb_mc_alu.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/add/sub, iterative shift-add multiply
// and restoring divide, with a valid/ready handshake on both sides.
module mc_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       CTRL,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] overflow,
  output logic             carry,
  output logic             zero,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] res_q, res_d, ovf_q, ovf_d;
  logic             cy_q, cy_d, dz_q, dz_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   add_w, sub_w, mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] mul_hi, mul_lo, div_q, div_r;
  logic             last;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (CTRL == OP_MUL)                  state_d = MUL;
          else if (CTRL == OP_DIV && B != '0)  state_d = DIV;
          else                                 state_d = DONE;
        end
      end
      MUL, DIV: if (last) state_d = DONE;
      DONE:     if (out_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Multiply: {hi,lo} shifts right, adding the multiplicand into hi when lo[0]=1.
  // Divide: {hi,lo} shifts left as {remainder,quotient}; a trial subtract decides each bit.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    ovf_d  = ovf_q;
    cy_d   = cy_q;
    dz_d   = dz_q;

    add_w    = {1'b0, A} + {1'b0, B};
    sub_w    = {1'b0, A} - {1'b0, B};
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi   = mul_sum[WIDTH:1];
    mul_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    div_q    = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    div_r    = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
    last     = (cnt_q == CW'(WIDTH - 1));

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d = '0;
          res_d = '0;
          ovf_d = '0;
          cy_d  = 1'b0;
          dz_d  = 1'b0;
          case (CTRL)
            OP_ADD: begin res_d = add_w[WIDTH-1:0]; cy_d = add_w[WIDTH]; end
            OP_SUB: begin res_d = sub_w[WIDTH-1:0]; cy_d = sub_w[WIDTH]; end
            OP_MUL: begin opnd_d = A; hi_d = '0; lo_d = B; end
            OP_DIV: begin
              if (B == '0) begin
                res_d = '1;
                ovf_d = A;
                dz_d  = 1'b1;
              end else begin
                opnd_d = B;
                hi_d   = '0;
                lo_d   = A;
              end
            end
            OP_AND:  res_d = A & B;
            OP_OR:   res_d = A | B;
            OP_XOR:  res_d = A ^ B;
            default: ;
          endcase
        end
      end
      MUL: begin
        hi_d  = mul_hi;
        lo_d  = mul_lo;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          res_d = mul_lo;
          ovf_d = mul_hi;
        end
      end
      DIV: begin
        hi_d  = div_r;
        lo_d  = div_q;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          res_d = div_q;
          ovf_d = div_r;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      ovf_q  <= '0;
      cy_q   <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
      ovf_q  <= ovf_d;
      cy_q   <= cy_d;
      dz_q   <= dz_d;
    end
  end

  assign result   = res_q;
  assign overflow = ovf_q;
  assign carry    = cy_q;
  assign div_zero = dz_q;
  assign zero     = (res_q == '0);

endmodule

// File: tb/tb_mc_alu.sv
// Self-checking bench for mc_alu (WIDTH=16): directed vector table, random ops
// against an arithmetic reference model, and backpressure/reset sequences.
module tb_mc_alu;

  localparam int unsigned W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  A, B;
  logic [2:0]    CTRL;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  result, overflow;
  logic          carry, zero, div_zero;

  int checks   = 0;
  int failures = 0;

  mc_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .CTRL(CTRL),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow),
    .carry(carry), .zero(zero), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] ovf;
    logic         cy;
    logic         dz;
    int           lat;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour straight from the opcode definitions.
  function automatic vec_t model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t v;
    longint unsigned ua = a, ub = b, p;
    v.ctrl = c; v.a = a; v.b = b;
    v.res = '0; v.ovf = '0; v.cy = 1'b0; v.dz = 1'b0; v.lat = 1;
    case (c)
      3'd0: begin p = ua + ub; v.res = W'(p); v.cy = (p >= 65536); end
      3'd1: begin v.res = W'(ua - ub); v.cy = (ua < ub); end
      3'd2: begin p = ua * ub; v.res = W'(p); v.ovf = W'(p >> 16); v.lat = 17; end
      3'd3: begin
        if (ub == 0) begin v.res = 16'hFFFF; v.ovf = a; v.dz = 1'b1; end
        else begin v.res = W'(ua / ub); v.ovf = W'(ua % ub); v.lat = 17; end
      end
      3'd4: v.res = a & b;
      3'd5: v.res = a | b;
      3'd6: v.res = a ^ b;
      default: ;
    endcase
    return v;
  endfunction

  // Issue one op, optionally keep in_valid asserted with junk while busy,
  // measure latency, check outputs, then complete the handshake.
  task automatic run_op(input string tag, input vec_t e, input bit noise);
    int lat;
    chk({tag, "_in_ready_pre"}, in_ready, 1);
    A = e.a; B = e.b; CTRL = e.ctrl; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = noise;
    A = W'($urandom); B = W'($urandom); CTRL = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      A = W'($urandom); B = W'($urandom); CTRL = 3'($urandom);
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"},  lat,      e.lat);
    chk({tag, "_result"},   result,   e.res);
    chk({tag, "_overflow"}, overflow, e.ovf);
    chk({tag, "_carry"},    carry,    e.cy);
    chk({tag, "_div_zero"}, div_zero, e.dz);
    chk({tag, "_zero"},     zero,     (e.res == '0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_in_ready_post"},  in_ready,  1);
    chk({tag, "_out_valid_post"}, out_valid, 0);
  endtask

  vec_t vecs[15];
  vec_t e;
  bit   seen;

  initial begin
    vecs[0]  = '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 1};
    vecs[1]  = '{3'b000, 16'h1234, 16'h1111, 16'h2345, 16'h0000, 1'b0, 1'b0, 1};
    vecs[2]  = '{3'b001, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 1};
    vecs[3]  = '{3'b001, 16'h0005, 16'h0003, 16'h0002, 16'h0000, 1'b0, 1'b0, 1};
    vecs[4]  = '{3'b010, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 17};
    vecs[5]  = '{3'b010, 16'h0007, 16'h0009, 16'h003F, 16'h0000, 1'b0, 1'b0, 17};
    vecs[6]  = '{3'b010, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0, 17};
    vecs[7]  = '{3'b010, 16'h8000, 16'h0002, 16'h0000, 16'h0001, 1'b0, 1'b0, 17};
    vecs[8]  = '{3'b011, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 17};
    vecs[9]  = '{3'b011, 16'd5,    16'd0,    16'hFFFF, 16'd5,    1'b0, 1'b1, 1};
    vecs[10] = '{3'b011, 16'h0003, 16'h0010, 16'h0000, 16'h0003, 1'b0, 1'b0, 17};
    vecs[11] = '{3'b100, 16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 1'b0, 1'b0, 1};
    vecs[12] = '{3'b101, 16'hF0F0, 16'h0F0F, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1};
    vecs[13] = '{3'b110, 16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 1'b0, 1'b0, 1};
    vecs[14] = '{3'b111, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b0, 1'b0, 1};

    rst = 1'b1; A = '0; B = '0; CTRL = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result",    result,    0);
    chk("rst_overflow",  overflow,  0);
    chk("rst_carry",     carry,     0);
    chk("rst_div_zero",  div_zero,  0);
    chk("rst_zero",      zero,      1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 15; i++) run_op($sformatf("vec%0d", i), vecs[i], 1'b0);

    // Random ops, half of them with in_valid/operands churning while busy
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic [2:0]   rc;
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      rc = 3'($urandom_range(0, 7));
      e = model(rc, ra, rb);
      run_op($sformatf("rnd%0d_op%0d", i, rc), e, 1'(i % 2));
    end

    // Backpressure: sub 3-5 held with out_ready=0 and in_valid=1
    A = 16'd3; B = 16'd5; CTRL = 3'b001; in_valid = 1'b1;
    @(posedge clk); #1;
    A = 16'h7777; B = 16'h1111; CTRL = 3'b010;
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready",  in_ready,  0);
      chk("bp_result",    result,    16'hFFFE);
      chk("bp_carry",     carry,     1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_in_ready",  in_ready,  1);
    chk("bp_release_out_valid", out_valid, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a multiply
    A = 16'd7; B = 16'd9; CTRL = 3'b010; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready",  in_ready,  1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result",    result,    0);
    chk("midrst_overflow",  overflow,  0);
    chk("midrst_zero",      zero,      1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("midrst_no_out_valid", seen, 0);
    e = model(3'b010, 16'd7, 16'd9);
    run_op("midrst_mul_again", e, 1'b0);
    chk("midrst_mul_again_result", result, 63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
